ex_mdu: RTL and testbench

Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline. It consumes operands and the decoded operation from the ID/EX pipeline register and owns the HI/LO architectural registers. It models multi-cycle latency with a busy counter. The hazard unit uses its busy output to stall HI/LO-touching instructions in ID, and its read data feeds the EX result mux for mfhi/mflo.

---
 rtl/ex_mdu_pkg.sv | 37 +++
 rtl/ex_mdu_arith.sv | 48 ++++
 rtl/ex_mdu.sv | 121 ++++++++++++
 tb/tb_ex_mdu.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op codes,
// FSM state encoding, default latencies and the busy-counter width helper.
package mdu_defs;

  // Operation codes carried on mdu_i_op.
  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mduState_t;

  // Counter must hold the larger of the two latencies.
  function automatic int unsigned cntWidth(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

  // True for the ops that occupy the unit for multiple cycles.
  function automatic logic isMulDiv(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/ex_mdu_arith.sv
// mdu_arith: purely combinational 64-bit {hi,lo} result for MULT/MULTU/DIV/DIVU.
// Ports: op (4b op code), rsData/rtData (operands), hi/lo (result halves).
// Divide by zero yields an unspecified but deterministic value; the caller never commits it.
module mdu_arith
  import mdu_defs::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rsData,
  input  logic [31:0] rtData,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [63:0] prodS;
  logic [63:0] prodU;
  logic [31:0] absA;
  logic [31:0] absB;
  logic [31:0] divisor;
  logic [31:0] magQ;
  logic [31:0] magR;

  always_comb begin
    prodS   = $signed({{32{rsData[31]}}, rsData}) * $signed({{32{rtData[31]}}, rtData});
    prodU   = {32'd0, rsData} * {32'd0, rtData};
    // Signed divide works on magnitudes; 0x80000000 is its own magnitude as unsigned.
    absA    = rsData[31] ? (32'd0 - rsData) : rsData;
    absB    = rtData[31] ? (32'd0 - rtData) : rtData;
    divisor = (op == OP_DIV) ? absB : rtData;
    if (divisor == 32'd0) divisor = 32'd1;
    magQ    = ((op == OP_DIV) ? absA : rsData) / divisor;
    magR    = ((op == OP_DIV) ? absA : rsData) % divisor;

    hi = 32'd0;
    lo = 32'd0;
    case (op)
      OP_MULT:  begin hi = prodS[63:32]; lo = prodS[31:0]; end
      OP_MULTU: begin hi = prodU[63:32]; lo = prodU[31:0]; end
      OP_DIV: begin
        // Quotient truncates toward zero; remainder follows the dividend's sign.
        lo = (rsData[31] ^ rtData[31]) ? (32'd0 - magQ) : magQ;
        hi = rsData[31] ? (32'd0 - magR) : magR;
      end
      OP_DIVU:  begin hi = magR; lo = magQ; end
      default:  begin hi = 32'd0; lo = 32'd0; end
    endcase
  end

endmodule

// File: rtl/ex_mdu.sv
// ex_mdu: EX-stage multiply/divide unit owning the HI/LO registers.
// Ports: clk, reset (sync, active-high); mdu_i_op/start/cancel/rsData/rtData issue
// interface; mdu_o_busy (registered), mdu_o_startOrBusy (comb, to hazard unit),
// mdu_o_HI/mdu_o_LO (architectural regs), mdu_o_readData (comb, MFHI/MFLO data).
module ex_mdu
  import mdu_defs::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mdu_i_op,
  input  logic        mdu_i_start,
  input  logic        mdu_i_cancel,
  input  logic [31:0] mdu_i_rsData,
  input  logic [31:0] mdu_i_rtData,
  output logic        mdu_o_busy,
  output logic        mdu_o_startOrBusy,
  output logic [31:0] mdu_o_HI,
  output logic [31:0] mdu_o_LO,
  output logic [31:0] mdu_o_readData
);

  localparam int unsigned CNT_W = cntWidth(MULT_CYCLES, DIV_CYCLES);

  mduState_t        state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [31:0]      hi, hiNext, lo, loNext;
  logic [31:0]      pendHi, pendHiNext, pendLo, pendLoNext;
  logic             busy, busyNext;
  logic [31:0]      arithHi, arithLo;
  logic             issue;

  mdu_arith uArith (
    .op     (mdu_i_op),
    .rsData (mdu_i_rsData),
    .rtData (mdu_i_rtData),
    .hi     (arithHi),
    .lo     (arithLo)
  );

  // State, counter and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      pendHi <= 32'd0;
      pendLo <= 32'd0;
      busy   <= 1'b0;
    end else begin
      state  <= stateNext;
      cnt    <= cntNext;
      hi     <= hiNext;
      lo     <= loNext;
      pendHi <= pendHiNext;
      pendLo <= pendLoNext;
      busy   <= busyNext;
    end
  end

  // Next-state: issue from IDLE only; in-flight ops run to completion regardless of cancel.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    hiNext     = hi;
    loNext     = lo;
    pendHiNext = pendHi;
    pendLoNext = pendLo;
    issue      = mdu_i_start && !mdu_i_cancel && (state == ST_IDLE);

    case (state)
      ST_IDLE: begin
        if (issue) begin
          case (mdu_i_op)
            OP_MULT, OP_MULTU: begin
              stateNext  = ST_MUL;
              cntNext    = CNT_W'(MULT_CYCLES);
              pendHiNext = arithHi;
              pendLoNext = arithLo;
            end
            OP_DIV, OP_DIVU: begin
              if (mdu_i_rtData != 32'd0) begin
                stateNext  = ST_DIV;
                cntNext    = CNT_W'(DIV_CYCLES);
                pendHiNext = arithHi;
                pendLoNext = arithLo;
              end
            end
            OP_MTHI: hiNext = mdu_i_rsData;
            OP_MTLO: loNext = mdu_i_rsData;
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        if (cnt == CNT_W'(1)) begin
          stateNext = ST_IDLE;
          cntNext   = '0;
          hiNext    = pendHi;
          loNext    = pendLo;
        end else begin
          cntNext = cnt - CNT_W'(1);
        end
      end
      default: stateNext = ST_IDLE;
    endcase

    busyNext = (stateNext != ST_IDLE);
  end

  assign mdu_o_busy        = busy;
  assign mdu_o_HI          = hi;
  assign mdu_o_LO          = lo;
  assign mdu_o_startOrBusy = (mdu_i_start && isMulDiv(mdu_i_op)) || busy;
  assign mdu_o_readData    = (mdu_i_op == OP_MFHI) ? hi :
                             (mdu_i_op == OP_MFLO) ? lo : 32'd0;

endmodule

// File: tb/tb_ex_mdu.sv
// Testbench for ex_mdu: directed vectors with literal expectations plus an
// arithmetic reference model compared against every output on each falling edge.
module tb_ex_mdu;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  localparam logic [3:0] NONE = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4,
                         MTHI = 4'd5, MTLO = 4'd6, MFHI = 4'd7, MFLO = 4'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op;
  logic        start, cancel;
  logic [31:0] rs, rt;
  logic        busy, startOrBusy;
  logic [31:0] hiOut, loOut, readData;

  int errors = 0;
  int checks = 0;
  bit chkEn  = 1'b0;
  int viol   = 0;

  // Reference model state.
  logic [31:0] mHi = 32'd0, mLo = 32'd0, pHi = 32'd0, pLo = 32'd0;
  int          mLeft = 0;

  ex_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk               (clk),
    .reset             (reset),
    .mdu_i_op          (op),
    .mdu_i_start       (start),
    .mdu_i_cancel      (cancel),
    .mdu_i_rsData      (rs),
    .mdu_i_rtData      (rt),
    .mdu_o_busy        (busy),
    .mdu_o_startOrBusy (startOrBusy),
    .mdu_o_HI          (hiOut),
    .mdu_o_LO          (loOut),
    .mdu_o_readData    (readData)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: architectural behaviour in plain arithmetic.
  always @(posedge clk) begin
    longint      sp, q, r;
    logic [63:0] up;
    if (reset) begin
      mHi = 32'd0; mLo = 32'd0; mLeft = 0;
    end else if (mLeft > 0) begin
      mLeft--;
      if (mLeft == 0) begin mHi = pHi; mLo = pLo; end
    end else if (start && !cancel) begin
      case (op)
        MULT: begin
          sp = longint'($signed(rs)) * longint'($signed(rt));
          pHi = sp[63:32]; pLo = sp[31:0]; mLeft = MULT_N;
        end
        MULTU: begin
          up = 64'(rs) * 64'(rt);
          pHi = up[63:32]; pLo = up[31:0]; mLeft = MULT_N;
        end
        DIV: if (rt != 0) begin
          q = longint'($signed(rs)) / longint'($signed(rt));
          r = longint'($signed(rs)) % longint'($signed(rt));
          pLo = q[31:0]; pHi = r[31:0]; mLeft = DIV_N;
        end
        DIVU: if (rt != 0) begin
          pLo = rs / rt; pHi = rs % rt; mLeft = DIV_N;
        end
        MTHI: mHi = rs;
        MTLO: mLo = rs;
        default: ;
      endcase
    end
  end

  // Protocol-violation monitor: issue attempts while the unit is busy.
  always @(posedge clk) if (!reset && start && busy) viol++;

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chkEn) begin
      checkEq("model_busy", 32'(busy), 32'(mLeft > 0));
      checkEq("model_HI", hiOut, mHi);
      checkEq("model_LO", loOut, mLo);
      checkEq("model_readData", readData, (op == MFHI) ? mHi : (op == MFLO) ? mLo : 32'd0);
      checkEq("model_startOrBusy", 32'(startOrBusy),
              32'((start && (op >= MULT) && (op <= DIVU)) || (mLeft > 0)));
    end
  end

  // Drive one issue cycle, starting just after the current time step.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic c);
    #1;
    op = o; rs = a; rt = b; start = 1'b1; cancel = c;
    @(posedge clk);
    #1;
    start = 1'b0; cancel = 1'b0; op = NONE;
  endtask

  // Count busy cycles until idle; ends on the first idle falling edge.
  task automatic runBusy(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) return;
      n++;
    end
    checkEq("busy_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1; op = NONE; start = 1'b0; cancel = 1'b0; rs = 32'd0; rt = 32'd0;
    @(posedge clk); #1 chkEn = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checkEq("reset_HI", hiOut, 32'd0);
    checkEq("reset_LO", loOut, 32'd0);
    checkEq("reset_busy", 32'(busy), 32'd0);

    issue(MULT, 32'hFFFFFFFF, 32'd2, 1'b0);
    runBusy(n);
    checkEq("mult_cycles", 32'(n), 32'd5);
    checkEq("mult_HI", hiOut, 32'hFFFFFFFF);
    checkEq("mult_LO", loOut, 32'hFFFFFFFE);

    issue(MULTU, 32'hFFFFFFFF, 32'd2, 1'b0);
    runBusy(n);
    checkEq("multu_HI", hiOut, 32'h00000001);
    checkEq("multu_LO", loOut, 32'hFFFFFFFE);

    issue(DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    runBusy(n);
    checkEq("div_cycles", 32'(n), 32'd10);
    checkEq("div_LO", loOut, 32'hFFFFFFFD);
    checkEq("div_HI", hiOut, 32'hFFFFFFFF);

    issue(DIVU, 32'd7, 32'd2, 1'b0);
    runBusy(n);
    checkEq("divu_LO", loOut, 32'd3);
    checkEq("divu_HI", hiOut, 32'd1);

    issue(DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    runBusy(n);
    checkEq("divovf_LO", loOut, 32'h80000000);
    checkEq("divovf_HI", hiOut, 32'd0);

    issue(DIV, 32'd5, 32'd0, 1'b0);
    runBusy(n);
    checkEq("div0_cycles", 32'(n), 32'd0);
    checkEq("div0_LO", loOut, 32'h80000000);
    checkEq("div0_HI", hiOut, 32'd0);

    issue(MTHI, 32'h12345678, 32'd0, 1'b1);
    @(negedge clk);
    checkEq("mthi_cancel_HI", hiOut, 32'd0);
    issue(MTHI, 32'h12345678, 32'd0, 1'b0);
    @(negedge clk);
    checkEq("mthi_HI", hiOut, 32'h12345678);
    #1 op = MFHI;
    #1 checkEq("mfhi_readData", readData, 32'h12345678);
    op = MFLO;
    #1 checkEq("mflo_readData", readData, 32'h80000000);
    op = NONE;

    // Cancelled MULT: hazard output still raised, but nothing issues.
    @(negedge clk); #1;
    op = MULT; rs = 32'd3; rt = 32'd3; start = 1'b1; cancel = 1'b1;
    #1 checkEq("cancel_startOrBusy", 32'(startOrBusy), 32'd1);
    @(posedge clk); #1 start = 1'b0; cancel = 1'b0; op = NONE;
    @(negedge clk);
    checkEq("cancel_busy", 32'(busy), 32'd0);

    // Reset during the third busy cycle aborts the multiply.
    issue(MULT, 32'd3, 32'd4, 1'b0);
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checkEq("rstmid_busy", 32'(busy), 32'd0);
    checkEq("rstmid_HI", hiOut, 32'd0);
    checkEq("rstmid_LO", loOut, 32'd0);

    // Start while busy is ignored; the original result lands on schedule.
    issue(MULT, 32'd6, 32'd7, 1'b0);
    repeat (2) @(negedge clk);
    #1 op = DIVU; rs = 32'd100; rt = 32'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0; op = NONE;
    runBusy(n);
    checkEq("overlap_cycles", 32'(n), 32'd3);
    checkEq("overlap_HI", hiOut, 32'd0);
    checkEq("overlap_LO", loOut, 32'd42);
    checkEq("overlap_violations", 32'(viol), 32'd1);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
